// File: rtl/pixel_fetch_pipeline_if.sv
// Pixel-fetch bus: per-pixel addresses/controls in, ROM read ports, palette write port, VGA out.
// The master side is the pixel source/ROMs/CPU; the slave side is the fetch pipeline.
interface pixel_fetch_pipeline_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned IDX_W  = 4
);
    logic              drawBG;
    logic [ADDR_W-1:0] addrBG;
    logic              drawSpr;
    logic [ADDR_W-1:0] addrSpr;
    logic              blank_n;
    logic              hs_in;
    logic              vs_in;

    logic              map_select_req;
    logic              map_select;

    logic [ADDR_W-1:0] bg_rom_addr;
    logic [IDX_W-1:0]  bg_rom_data;
    logic [ADDR_W-1:0] spr_rom_addr;
    logic [IDX_W-1:0]  spr_rom_data;

    logic              pal_we;
    logic [IDX_W-1:0]  pal_waddr;
    logic [23:0]       pal_wdata;

    logic [7:0]        VGA_R;
    logic [7:0]        VGA_G;
    logic [7:0]        VGA_B;
    logic              VGA_HS;
    logic              VGA_VS;
    logic              VGA_BLANK_N;

    modport master (
        output drawBG, addrBG, drawSpr, addrSpr, blank_n, hs_in, vs_in,
        output map_select_req,
        input  map_select,
        input  bg_rom_addr, spr_rom_addr,
        output bg_rom_data, spr_rom_data,
        output pal_we, pal_waddr, pal_wdata,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
    );

    modport slave (
        input  drawBG, addrBG, drawSpr, addrSpr, blank_n, hs_in, vs_in,
        input  map_select_req,
        output map_select,
        output bg_rom_addr, spr_rom_addr,
        input  bg_rom_data, spr_rom_data,
        input  pal_we, pal_waddr, pal_wdata,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
    );
endinterface

// File: rtl/pixel_fetch_pipeline.sv
// Sprite/background fetch, priority composite and palette lookup feeding VGA outputs.
// Three-register latency: address register, ROM data register, palette/VGA register.
module pixel_fetch_pipeline #(
    parameter int unsigned ADDR_W          = 18,
    parameter int unsigned IDX_W           = 4,
    parameter int unsigned PAL_DEPTH       = 16,
    parameter int unsigned TRANSPARENT_IDX = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    pixel_fetch_pipeline_if.slave bus
);
    localparam int unsigned RGB_W  = 24;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned PAL_AW = $clog2(PAL_DEPTH);
    localparam int unsigned GREY_STEP = 17;

    typedef struct packed {
        logic draw_bg;
        logic draw_spr;
        logic blank_n;
        logic hs;
        logic vs;
    } ctrl_t;

    // Idle controls: nothing drawn, blanked, syncs inactive (high).
    localparam ctrl_t CTRL_IDLE = '{draw_bg: 1'b0, draw_spr: 1'b0, blank_n: 1'b0, hs: 1'b1, vs: 1'b1};

    ctrl_t             s0;
    ctrl_t             s1;
    logic              vs_q;
    logic [RGB_W-1:0]  pal [PAL_DEPTH];

    logic              spr_hit_c;
    logic              use_pal_c;
    logic [IDX_W-1:0]  sel_idx_c;
    logic [RGB_W-1:0]  rgb_c;

    // Stage 0: ROM addresses and controls.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s0               <= CTRL_IDLE;
            bus.bg_rom_addr  <= '0;
            bus.spr_rom_addr <= '0;
        end else begin
            s0.draw_bg       <= bus.drawBG;
            s0.draw_spr      <= bus.drawSpr;
            s0.blank_n       <= bus.blank_n;
            s0.hs            <= bus.hs_in;
            s0.vs            <= bus.vs_in;
            bus.bg_rom_addr  <= bus.addrBG;
            bus.spr_rom_addr <= bus.addrSpr;
        end
    end

    // Stage 1: the ROM output register holds the indices; controls ride alongside it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1 <= CTRL_IDLE;
        end else begin
            s1 <= s0;
        end
    end

    // Sprite wins unless transparent; blanking or no source gives black.
    always_comb begin
        spr_hit_c = 1'b0;
        use_pal_c = 1'b0;
        sel_idx_c = bus.bg_rom_data;
        rgb_c     = '0;
        spr_hit_c = s1.draw_spr && (bus.spr_rom_data != IDX_W'(TRANSPARENT_IDX));
        if (spr_hit_c) begin
            sel_idx_c = bus.spr_rom_data;
        end
        use_pal_c = s1.blank_n && (spr_hit_c || s1.draw_bg);
        if (use_pal_c) begin
            rgb_c = pal[PAL_AW'(sel_idx_c)];
        end
    end

    // Stage 2: registered palette lookup and delay-matched syncs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.VGA_R       <= '0;
            bus.VGA_G       <= '0;
            bus.VGA_B       <= '0;
            bus.VGA_HS      <= 1'b1;
            bus.VGA_VS      <= 1'b1;
            bus.VGA_BLANK_N <= 1'b0;
        end else begin
            bus.VGA_R       <= rgb_c[2*CH_W +: CH_W];
            bus.VGA_G       <= rgb_c[CH_W +: CH_W];
            bus.VGA_B       <= rgb_c[0 +: CH_W];
            bus.VGA_HS      <= s1.hs;
            bus.VGA_VS      <= s1.vs;
            bus.VGA_BLANK_N <= s1.blank_n;
        end
    end

    // Palette file; a same-cycle write is seen by the lookup only from the next cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < PAL_DEPTH; i++) begin
                pal[PAL_AW'(i)] <= {3{CH_W'(i * GREY_STEP)}};
            end
        end else if (bus.pal_we) begin
            pal[PAL_AW'(bus.pal_waddr)] <= bus.pal_wdata;
        end
    end

    // Map select only follows the request on a falling edge of vs_in.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_q           <= 1'b1;
            bus.map_select <= 1'b0;
        end else begin
            vs_q <= bus.vs_in;
            if (vs_q && !bus.vs_in) begin
                bus.map_select <= bus.map_select_req;
            end
        end
    end
endmodule

// File: tb/tb_pixel_fetch_pipeline.sv
// Directed bench for pixel_fetch_pipeline with synchronous ROM models driven from the bench.
module tb_pixel_fetch_pipeline;
    logic Clk = 1'b0;
    logic Reset;
    int   tests = 0;
    int   fails = 0;

    pixel_fetch_pipeline_if bus ();

    pixel_fetch_pipeline dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] bg_rom(input logic [17:0] a);
        return (a == 18'h00ABC) ? 4'd5 : a[3:0];
    endfunction

    // Synchronous ROMs: data valid one Clk after the address.
    always @(posedge Clk) begin
        bus.bg_rom_data  <= bg_rom(bus.bg_rom_addr);
        bus.spr_rom_data <= bus.spr_rom_addr[3:0];
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic dbg, input logic [17:0] abg, input logic dspr,
                       input logic [17:0] aspr, input logic blank, input logic hs, input logic vs);
        bus.drawBG  = dbg;
        bus.addrBG  = abg;
        bus.drawSpr = dspr;
        bus.addrSpr = aspr;
        bus.blank_n = blank;
        bus.hs_in   = hs;
        bus.vs_in   = vs;
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B};
    endfunction

    initial begin
        Reset = 1'b1;
        pix(1'b0, 18'h0, 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        bus.map_select_req = 1'b0;
        bus.pal_we    = 1'b0;
        bus.pal_waddr = 4'h0;
        bus.pal_wdata = 24'h0;
        tick();
        tick();
        Reset = 1'b0;

        check("rst_rgb", rgb(), 32'h0);
        check("rst_hs", 32'(bus.VGA_HS), 32'h1);
        check("rst_vs", 32'(bus.VGA_VS), 32'h1);
        check("rst_blank", 32'(bus.VGA_BLANK_N), 32'h0);
        check("rst_map", 32'(bus.map_select), 32'h0);
        check("rst_bgaddr", 32'(bus.bg_rom_addr), 32'h0);

        // Latency and alignment: pixel A (hs low), then pixel B.
        pix(1'b1, 18'h00ABC, 1'b0, 18'h0, 1'b1, 1'b0, 1'b1);
        tick();
        check("bg_addr_1clk", 32'(bus.bg_rom_addr), 32'h00ABC);
        pix(1'b1, 18'h00003, 1'b0, 18'h0, 1'b1, 1'b1, 1'b1);
        tick();
        check("lat_2clk_blank", 32'(bus.VGA_BLANK_N), 32'h0);
        check("lat_2clk_rgb", rgb(), 32'h0);
        tick();
        check("a_rgb", rgb(), 32'h555555);
        check("a_hs", 32'(bus.VGA_HS), 32'h0);
        check("a_blank", 32'(bus.VGA_BLANK_N), 32'h1);
        tick();
        check("b_rgb", rgb(), 32'h333333);
        check("b_hs", 32'(bus.VGA_HS), 32'h1);

        // Transparency, priority, no source, blanking, palette write hazard.
        pix(1'b1, 18'h00003, 1'b1, 18'h00000, 1'b1, 1'b1, 1'b1);
        tick();
        pix(1'b1, 18'h00003, 1'b1, 18'h00009, 1'b1, 1'b1, 1'b1);
        tick();
        pix(1'b0, 18'h00007, 1'b0, 18'h00008, 1'b1, 1'b1, 1'b1);
        tick();
        check("spr_transparent", rgb(), 32'h333333);
        pix(1'b1, 18'h0000F, 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        tick();
        check("spr_priority", rgb(), 32'h999999);
        pix(1'b1, 18'h00005, 1'b0, 18'h0, 1'b1, 1'b1, 1'b1);
        tick();
        check("no_source_rgb", rgb(), 32'h0);
        check("no_source_blank", 32'(bus.VGA_BLANK_N), 32'h1);
        pix(1'b1, 18'h00005, 1'b0, 18'h0, 1'b1, 1'b1, 1'b1);
        tick();
        check("blank_rgb", rgb(), 32'h0);
        check("blank_n_out", 32'(bus.VGA_BLANK_N), 32'h0);
        pix(1'b1, 18'h00002, 1'b0, 18'h0, 1'b1, 1'b1, 1'b1);
        bus.pal_we    = 1'b1;
        bus.pal_waddr = 4'h5;
        bus.pal_wdata = 24'hFF0000;
        tick();
        bus.pal_we = 1'b0;
        check("pal_old_value", rgb(), 32'h555555);
        pix(1'b1, 18'h00005, 1'b0, 18'h0, 1'b1, 1'b1, 1'b1);
        tick();
        check("pal_new_value", rgb(), 32'hFF0000);
        tick();
        check("pal_other_entry", rgb(), 32'h222222);
        tick();
        check("pal_new_held", rgb(), 32'hFF0000);

        // Map select: pulse before the edge has no effect, level at the edge is taken.
        bus.map_select_req = 1'b1;
        tick();
        bus.map_select_req = 1'b0;
        tick();
        check("map_pulse_mid", 32'(bus.map_select), 32'h0);
        bus.vs_in = 1'b0;
        tick();
        check("map_pulse_lost", 32'(bus.map_select), 32'h0);
        bus.vs_in = 1'b1;
        tick();
        bus.map_select_req = 1'b1;
        tick();
        tick();
        check("map_hold_midframe", 32'(bus.map_select), 32'h0);
        bus.vs_in = 1'b0;
        tick();
        check("map_at_edge", 32'(bus.map_select), 32'h1);
        bus.vs_in = 1'b1;
        bus.map_select_req = 1'b0;
        tick();
        tick();
        check("map_rising_no_effect", 32'(bus.map_select), 32'h1);

        // Reset mid-stream flushes three outputs and restores the grey ramp.
        pix(1'b1, 18'h00005, 1'b0, 18'h0, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        check("pre_rst_rgb", rgb(), 32'hFF0000);
        check("pre_rst_hs", 32'(bus.VGA_HS), 32'h0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mid_rst_map", 32'(bus.map_select), 32'h0);
        check("mid_rst_bgaddr", 32'(bus.bg_rom_addr), 32'h0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("flush%0d_rgb", k), rgb(), 32'h0);
            check($sformatf("flush%0d_hs", k), 32'(bus.VGA_HS), 32'h1);
            check($sformatf("flush%0d_vs", k), 32'(bus.VGA_VS), 32'h1);
            check($sformatf("flush%0d_blank", k), 32'(bus.VGA_BLANK_N), 32'h0);
            tick();
        end
        check("post_rst_grey", rgb(), 32'h555555);
        check("post_rst_hs", 32'(bus.VGA_HS), 32'h0);
        check("post_rst_blank", 32'(bus.VGA_BLANK_N), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
